// File: rtl/memory_pkg.sv
// Shared memory-port types used by the fetch path, the load-store unit and
// the port arbiter.
package memory_pkg;

  typedef enum logic [1:0] {
    MEM_ACC_INSTR = 2'd0,
    MEM_ACC_LOAD  = 2'd1,
    MEM_ACC_STORE = 2'd2,
    MEM_ACC_AMO   = 2'd3
  } mem_acc_type_t;

  typedef struct packed {
    mem_acc_type_t acc_type;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } mem_req_t;

  typedef struct packed {
    mem_acc_type_t acc_type;
    logic [31:0]   rdata;
  } mem_ans_t;

  typedef enum logic {MEM_REQ_INSTR, MEM_REQ_DATA} mem_requester_t;

endpackage

// File: rtl/mem_arb_credit_cnt.sv
// Per-requester credit tracking: requests accepted by memory but not yet
// answered, plus how many of those answers are stale and must be dropped.
module mem_arb_credit_cnt #(
  parameter int MAX_OUTST = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  input  logic answer_i,
  input  logic flush_i,
  input  logic slot_owned_i,
  output logic full_o,
  output logic discarding_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW:0]   used;

  always_comb begin
    inflight_d = inflight_q;
    if (issue_i && !answer_i) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue_i && answer_i) begin
      inflight_d = inflight_q - CW'(1);
    end
    // A flush turns every still-unanswered request into a stale one.
    discard_d = discard_q;
    if (flush_i) begin
      discard_d = inflight_d;
    end else if (answer_i && discard_q != '0) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  assign used         = {1'b0, inflight_q} + (CW+1)'(slot_owned_i);
  assign full_o       = used >= (CW+1)'(MAX_OUTST);
  assign discarding_o = discard_q != '0;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(issue_i && !answer_i && inflight_q == CW'(MAX_OUTST)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(answer_i && !issue_i && inflight_q == '0));

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between instruction fetch and the LSU: round-robin
// into a registered request slot, credit-limited, answers routed by acc_type.
module mem_req_arbiter
  import memory_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     instr_flush_i,
  input  logic     data_flush_i,
  input  logic     instr_valid_i,
  output logic     instr_ready_o,
  input  mem_req_t instr_req_i,
  output logic     instr_valid_o,
  input  logic     instr_ready_i,
  output mem_ans_t instr_ans_o,
  input  logic     data_valid_i,
  output logic     data_ready_o,
  input  mem_req_t data_req_i,
  output logic     data_valid_o,
  input  logic     data_ready_i,
  output mem_ans_t data_ans_o,
  output logic     mem_valid_o,
  input  logic     mem_ready_i,
  output mem_req_t mem_req_o,
  input  logic     mem_valid_i,
  output logic     mem_ready_o,
  input  mem_ans_t mem_ans_i
);

  // Handshakes: every valid/ready pair transfers on a rising edge where both
  // are high; a valid never waits on its own ready.
  logic           mem_valid_q, mem_valid_d;
  mem_req_t       mem_req_q, mem_req_d;
  mem_requester_t owner_q, owner_d;
  mem_requester_t last_grant_q, last_grant_d;

  logic full_instr, full_data, disc_instr, disc_data;
  logic elig_instr, elig_data, grant_instr, grant_data;
  logic slot_can_load, load, mem_hs, slot_flush, route_instr, ans_hs;

  assign slot_can_load = !mem_valid_q || mem_ready_i;
  assign elig_instr    = instr_valid_i && !instr_flush_i && !full_instr;
  assign elig_data     = data_valid_i && !data_flush_i && !full_data;
  assign grant_instr   = elig_instr && (!elig_data || last_grant_q == MEM_REQ_DATA);
  assign grant_data    = elig_data && !grant_instr;
  assign instr_ready_o = grant_instr && slot_can_load;
  assign data_ready_o  = grant_data && slot_can_load;
  assign load          = instr_ready_o || data_ready_o;
  assign mem_hs        = mem_valid_q && mem_ready_i;
  assign slot_flush    = mem_valid_q &&
                         ((owner_q == MEM_REQ_INSTR && instr_flush_i) ||
                          (owner_q == MEM_REQ_DATA && data_flush_i));

  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_req_d    = mem_req_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    if (load) begin
      mem_valid_d  = 1'b1;
      mem_req_d    = grant_instr ? instr_req_i : data_req_i;
      owner_d      = grant_instr ? MEM_REQ_INSTR : MEM_REQ_DATA;
      last_grant_d = owner_d;
    end else if (mem_hs || slot_flush) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_valid_q  <= 1'b0;
      mem_req_q    <= '0;
      owner_q      <= MEM_REQ_DATA;
      last_grant_q <= MEM_REQ_DATA;
    end else begin
      mem_valid_q  <= mem_valid_d;
      mem_req_q    <= mem_req_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_req_o   = mem_req_q;

  // Stale answers are swallowed here so the requester never sees them.
  assign route_instr   = mem_ans_i.acc_type == MEM_ACC_INSTR;
  assign instr_valid_o = mem_valid_i && route_instr && !disc_instr && !instr_flush_i;
  assign data_valid_o  = mem_valid_i && !route_instr && !disc_data && !data_flush_i;
  assign mem_ready_o   = route_instr ? (disc_instr || instr_ready_i)
                                     : (disc_data || data_ready_i);
  assign ans_hs        = mem_valid_i && mem_ready_o;
  assign instr_ans_o   = mem_ans_i;
  assign data_ans_o    = mem_ans_i;

  mem_arb_credit_cnt #(.MAX_OUTST(MAX_OUTST)) u_cnt_instr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_i      (mem_hs && owner_q == MEM_REQ_INSTR),
    .answer_i     (ans_hs && route_instr),
    .flush_i      (instr_flush_i),
    .slot_owned_i (mem_valid_q && owner_q == MEM_REQ_INSTR),
    .full_o       (full_instr),
    .discarding_o (disc_instr)
  );

  mem_arb_credit_cnt #(.MAX_OUTST(MAX_OUTST)) u_cnt_data (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_i      (mem_hs && owner_q == MEM_REQ_DATA),
    .answer_i     (ans_hs && !route_instr),
    .flush_i      (data_flush_i),
    .slot_owned_i (mem_valid_q && owner_q == MEM_REQ_DATA),
    .full_o       (full_data),
    .discarding_o (disc_data)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: a queue-level reference of the slot,
// the per-requester outstanding lists and an in-order memory.
module tb_mem_req_arbiter;
  import memory_pkg::*;

  localparam int MAX_OUTST = 2;

  logic     clk_i = 1'b0;
  logic     rst_i;
  logic     instr_flush_i, data_flush_i;
  logic     instr_valid_i, instr_ready_o, instr_valid_o, instr_ready_i;
  mem_req_t instr_req_i;
  mem_ans_t instr_ans_o;
  logic     data_valid_i, data_ready_o, data_valid_o, data_ready_i;
  mem_req_t data_req_i;
  mem_ans_t data_ans_o;
  logic     mem_valid_o, mem_ready_i, mem_valid_i, mem_ready_o;
  mem_req_t mem_req_o;
  mem_ans_t mem_ans_i;

  mem_req_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_flush_i(instr_flush_i), .data_flush_i(data_flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_req_i(instr_req_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_ans_o(instr_ans_o),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_req_i(data_req_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_ans_o(data_ans_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_ans_i(mem_ans_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    mem_requester_t who;
    mem_req_t       req;
  } slot_t;

  slot_t          exp_slot[$];   // accepted request waiting for memory (0 or 1 entry)
  logic [0:0]     out_i[$];      // per-requester issued-unanswered list, 1 = stale
  logic [0:0]     out_d[$];
  mem_req_t       mem_q[$];      // in-order memory: issued, not yet answered
  mem_requester_t m_last = MEM_REQ_DATA;

  // stimulus knobs (percent)
  int p_iv, p_dv, p_fl, p_mr, p_ans, p_rdy;
  bit ans_en;

  // ---------------- driver tasks ----------------
  function automatic mem_req_t rand_req(input bit is_instr);
    mem_req_t r;
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.be    = 4'($urandom);
    if (is_instr) r.acc_type = MEM_ACC_INSTR;
    else          r.acc_type = mem_acc_type_t'(2'($urandom_range(1, 3)));
    return r;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic drive_cycle();
    instr_valid_i = pct(p_iv);
    data_valid_i  = pct(p_dv);
    instr_req_i   = rand_req(1'b1);
    data_req_i    = rand_req(1'b0);
    instr_flush_i = pct(p_fl);
    data_flush_i  = pct(p_fl);
    mem_ready_i   = pct(p_mr);
    instr_ready_i = pct(p_rdy);
    data_ready_i  = pct(p_rdy);
    if (ans_en && mem_q.size() != 0 && pct(p_ans)) begin
      mem_valid_i        = 1'b1;
      mem_ans_i.acc_type = mem_q[0].acc_type;
      mem_ans_i.rdata    = mem_q[0].addr ^ 32'h5a5a_0000;
    end else begin
      mem_valid_i = 1'b0;
      mem_ans_i   = '0;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    drive_cycle();
  endtask

  task automatic set_knobs(input int iv, input int dv, input int fl, input int mr,
                           input int an, input int rd, input bit en);
    p_iv = iv; p_dv = dv; p_fl = fl; p_mr = mr; p_ans = an; p_rdy = rd; ans_en = en;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    bit    exp_mv, own_i, own_d, can_load, el_i, el_d, g_i, g_d;
    bit    r_i, stale, e_iv, e_dv, e_mr, have;
    slot_t s;
    if (rst_i) begin
      exp_slot.delete();
      out_i.delete();
      out_d.delete();
      mem_q.delete();
      m_last = MEM_REQ_DATA;
    end else begin
      exp_mv = exp_slot.size() != 0;
      check("mem_valid_o", mem_valid_o, exp_mv);
      if (exp_mv) check("mem_req_o", mem_req_o, exp_slot[0].req);
      own_i    = exp_mv && exp_slot[0].who == MEM_REQ_INSTR;
      own_d    = exp_mv && exp_slot[0].who == MEM_REQ_DATA;
      can_load = !exp_mv || mem_ready_i;
      el_i = instr_valid_i && !instr_flush_i && (out_i.size() + int'(own_i) < MAX_OUTST);
      el_d = data_valid_i && !data_flush_i && (out_d.size() + int'(own_d) < MAX_OUTST);
      g_i  = el_i && (!el_d || m_last == MEM_REQ_DATA);
      g_d  = el_d && !g_i;
      check("instr_ready_o", instr_ready_o, g_i && can_load);
      check("data_ready_o", data_ready_o, g_d && can_load);

      e_mr = 1'b0;
      have = 1'b0;
      r_i  = 1'b0;
      if (mem_valid_i) begin
        r_i  = mem_ans_i.acc_type == MEM_ACC_INSTR;
        have = r_i ? (out_i.size() != 0) : (out_d.size() != 0);
        if (!have) begin
          check("answer_has_owner", 1'b0, 1'b1);
        end else begin
          stale = r_i ? out_i[0][0] : out_d[0][0];
          e_iv  = r_i && !stale && !instr_flush_i;
          e_dv  = !r_i && !stale && !data_flush_i;
          e_mr  = stale ? 1'b1 : (r_i ? instr_ready_i : data_ready_i);
          check("instr_valid_o", instr_valid_o, e_iv);
          check("data_valid_o", data_valid_o, e_dv);
          check("mem_ready_o", mem_ready_o, e_mr);
          if (e_iv) check("instr_ans_o", instr_ans_o, mem_ans_i);
          if (e_dv) check("data_ans_o", data_ans_o, mem_ans_i);
        end
      end else begin
        check("instr_valid_idle", instr_valid_o, 1'b0);
        check("data_valid_idle", data_valid_o, 1'b0);
      end

      // state transitions taken at the coming rising edge
      if (exp_mv && mem_ready_i) begin
        s = exp_slot.pop_front();
        mem_q.push_back(s.req);
        if (s.who == MEM_REQ_INSTR) out_i.push_back(1'b0);
        else                        out_d.push_back(1'b0);
      end else if ((own_i && instr_flush_i) || (own_d && data_flush_i)) begin
        void'(exp_slot.pop_front());
      end
      if (mem_valid_i && have && e_mr) begin
        void'(mem_q.pop_front());
        if (r_i) void'(out_i.pop_front());
        else     void'(out_d.pop_front());
      end
      if (instr_flush_i) foreach (out_i[k]) out_i[k] = 1'b1;
      if (data_flush_i)  foreach (out_d[k]) out_d[k] = 1'b1;
      if (g_i && can_load) begin
        exp_slot.push_back('{MEM_REQ_INSTR, instr_req_i});
        m_last = MEM_REQ_INSTR;
      end else if (g_d && can_load) begin
        exp_slot.push_back('{MEM_REQ_DATA, data_req_i});
        m_last = MEM_REQ_DATA;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drain(input string name);
    bit done;
    set_knobs(0, 0, 0, 100, 100, 100, 1'b1);
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      done = mem_q.size() == 0 && exp_slot.size() == 0;
    end
    check(name, done, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1;
    set_knobs(0, 0, 0, 0, 0, 0, 1'b0);
    drive_cycle();
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_mem_valid", mem_valid_o, 1'b0);
    check("reset_mem_req", mem_req_o, '0);
    rst_i = 1'b0;

    // fetch alone, memory never answers: credits run out after MAX_OUTST
    set_knobs(100, 0, 0, 100, 0, 100, 1'b0);
    repeat (5) step();
    #1;
    check("credit_limit_instr_ready", instr_ready_o, 1'b0);
    drain("drain_after_credit");

    // both requesters saturating: grants alternate
    set_knobs(100, 100, 0, 100, 100, 100, 1'b1);
    repeat (30) step();
    drain("drain_after_alternate");

    // flush while the slot holds a fetch request and memory stalls
    @(posedge clk_i); #1;
    drive_cycle();
    instr_valid_i = 1'b1; data_valid_i = 1'b0; mem_ready_i = 1'b0;
    instr_flush_i = 1'b0; data_flush_i = 1'b0;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0; instr_flush_i = 1'b1;
    @(posedge clk_i); #1;
    instr_flush_i = 1'b0;
    check("flush_clears_slot", mem_valid_o, 1'b0);
    drain("drain_after_slot_flush");

    // randomized traffic under varied pressure, with a mid-stream reset
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0:       set_knobs(70, 70, 5, 70, 60, 80, 1'b1);
        1:       set_knobs(90, 90, 2, 40, 50, 50, 1'b1);
        default: set_knobs(50, 50, 15, 90, 90, 90, 1'b1);
      endcase
      repeat (1500) step();
      if (ph == 1) begin
        @(posedge clk_i); #1;
        rst_i       = 1'b1;
        mem_valid_i = 1'b0;
        #1;
        check("midreset_mem_valid", mem_valid_o, 1'b0);
        check("midreset_mem_req", mem_req_o, '0);
        check("midreset_instr_valid", instr_valid_o, 1'b0);
        check("midreset_data_valid", data_valid_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive_cycle();
      end
    end
    drain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
